// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared definitions for the mult/div sequencer: FSM state
//               encoding (3-bit) and the HI/LO source mux select values.
//               control_unit imports the same package, so the encodings
//               seen on both sides always agree.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_M_INIT = 3'd1,
    ST_M_RUN  = 3'd2,
    ST_D_INIT = 3'd3,
    ST_D_RUN  = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6,
    ST_DZ     = 3'd7
  } state_t;

  // mux_hi_lo select values
  localparam logic HL_SRC_DIV  = 1'b0;
  localparam logic HL_SRC_MULT = 1'b1;

endpackage : muldiv_sequencer_pkg
`default_nettype wire

// File: rtl/muldiv_sequencer_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_lat_counter
// Description : Latency counter (lat_counter) for the mult/div sequencer.
//               Loadable CNT_W-bit down-counter that saturates at zero.
// Ports       : clk      in  system clock, rising edge
//               reset    in  asynchronous active-low reset (count -> 0)
//               load     in  load load_val (has priority over dec)
//               load_val in  CNT_W-bit value to load
//               dec      in  decrement by one; ignored when already zero
//               is_zero  out count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] count;

  assign is_zero = (count == '0);

  // Saturating at zero keeps the counter from wrapping if dec were ever
  // held past the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero) begin
      count <= count - 1'b1;
    end
  end

endmodule : muldiv_sequencer_lat_counter
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Sequences the shared mult/div units and the HI/LO registers
//               for control_unit. Accepts a single-cycle start request in
//               IDLE, pulses the unit init, waits the unit latency, loads
//               HI/LO and pulses done. A divide with a zero divisor is
//               trapped before the divider is started.
// Ports       : clk          in  system clock, rising edge
//               reset        in  asynchronous active-low reset
//               start_mult   in  mult request (sampled in IDLE only)
//               start_div    in  div request (sampled in IDLE only)
//               div_src_mdr  in  dividend source: 1=MDR, 0=A
//               divisor      in  32-bit divisor, zero-checked at start_div
//               abort        in  flush the current sequence
//               mult_init    out one-cycle start pulse to mult
//               div_init     out one-cycle start pulse to div
//               div_op_sel   out mux_divSrcA select, held while busy
//               hl_src_sel   out mux_hi_lo select (0=div, 1=mult)
//               hl_load      out one-cycle HI/LO load
//               busy         out high in every state except IDLE
//               done         out one-cycle completion pulse
//               div_zero     out one-cycle divide-by-zero pulse
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        div_src_mdr,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        mult_init,
  output logic        div_init,
  output logic        div_op_sel,
  output logic        hl_src_sel,
  output logic        hl_load,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  // The INIT cycle loads N-1 so the following RUN state lasts exactly N
  // cycles (N-1 down to 0 inclusive).
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             accept;

  muldiv_sequencer_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero)
  );

  // A start is taken only in IDLE and only when no abort is pending.
  assign accept = (state == ST_IDLE) && !abort && (start_mult || start_div);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand/source selects change only on an accepted start and are held
  // afterwards so the HI/LO mux still points at the right unit in WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_op_sel <= 1'b0;
      hl_src_sel <= 1'b0;
    end else if (accept) begin
      div_op_sel <= div_src_mdr;
      hl_src_sel <= start_mult ? HL_SRC_MULT : HL_SRC_DIV;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = DIV_LOAD;
    case (state)
      ST_IDLE: begin
        if (!abort) begin
          if (start_mult) begin
            state_nxt = ST_M_INIT;
          end else if (start_div) begin
            state_nxt = (divisor == 32'd0) ? ST_DZ : ST_D_INIT;
          end
        end
      end
      ST_M_INIT: begin
        cnt_load     = 1'b1;
        cnt_load_val = MULT_LOAD;
        state_nxt    = ST_M_RUN;
      end
      ST_D_INIT: begin
        cnt_load     = 1'b1;
        cnt_load_val = DIV_LOAD;
        state_nxt    = ST_D_RUN;
      end
      ST_M_RUN, ST_D_RUN: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      ST_DZ:    state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Flush from any busy state; outputs are decoded from the registered
    // state, so the flush takes effect in the next cycle.
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // Moore output decode
  assign mult_init = (state == ST_M_INIT);
  assign div_init  = (state == ST_D_INIT);
  assign hl_load   = (state == ST_WRITE);
  assign done      = (state == ST_DONE) || (state == ST_DZ);
  assign div_zero  = (state == ST_DZ);
  assign busy      = (state != ST_IDLE);

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. Each issued request
//               pushes its expected pulse events (cycle + pulse pattern) to a
//               scoreboard queue; a negedge monitor pops and compares them
//               whenever the DUT raises a pulse, and also checks busy and the
//               held select outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int N = 32;

  // pulse pattern bit order: {mult_init, div_init, hl_load, done, div_zero}
  localparam logic [4:0] P_MI = 5'b10000;
  localparam logic [4:0] P_DI = 5'b01000;
  localparam logic [4:0] P_HL = 5'b00100;
  localparam logic [4:0] P_DN = 5'b00010;
  localparam logic [4:0] P_DZ = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic        div_src_mdr = 1'b0;
  logic [31:0] divisor = 32'd0;
  logic        abort = 1'b0;
  logic        mult_init, div_init, div_op_sel, hl_src_sel;
  logic        hl_load, busy, done, div_zero;

  ev_t  q[$];
  ev_t  ev;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  logic exp_src = 1'b0;
  logic exp_op = 1'b0;
  logic [4:0] pulses;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .MULT_CYCLES (N),
    .DIV_CYCLES  (N),
    .CNT_W       (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .div_src_mdr (div_src_mdr),
    .divisor     (divisor),
    .abort       (abort),
    .mult_init   (mult_init),
    .div_init    (div_init),
    .div_op_sel  (div_op_sel),
    .hl_src_sel  (hl_src_sel),
    .hl_load     (hl_load),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Drive a request for one edge; cyc after the edge is the sampling edge e.
  // Spec cycle c corresponds to cyc == e + c - 1.
  task automatic issue(input logic m, input logic d, input logic src,
                       input logic [31:0] dv, output int e);
    start_mult  = m;
    start_div   = d;
    div_src_mdr = src;
    divisor     = dv;
    tick();
    e          = cyc;
    start_mult = 1'b0;
    start_div  = 1'b0;
    exp_op     = src;
    exp_src    = m;
    if (m) begin
      q.push_back('{e, P_MI});
      q.push_back('{e + N + 1, P_HL});
      q.push_back('{e + N + 2, P_DN});
      busy_lo = e; busy_hi = e + N + 2;
    end else if (dv == 32'd0) begin
      q.push_back('{e, P_DN | P_DZ});
      busy_lo = e; busy_hi = e;
    end else begin
      q.push_back('{e, P_DI});
      q.push_back('{e + N + 1, P_HL});
      q.push_back('{e + N + 2, P_DN});
      busy_lo = e; busy_hi = e + N + 2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"},
        {27'd0, mult_init, div_init, hl_load, done, div_zero}, 32'd0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sels"}, {div_op_sel, hl_src_sel}, 0);
  endtask

  // Monitor: away from the active edge
  always @(negedge clk) begin
    chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
    chk("hl_src_sel", hl_src_sel, exp_src);
    chk("div_op_sel", div_op_sel, exp_op);
    pulses = {mult_init, div_init, hl_load, done, div_zero};
    if (pulses !== 5'd0) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", pulses, 0);
      end else begin
        ev = q.pop_front();
        chk("ev_cycle", cyc, ev.cyc);
        chk("ev_pulses", pulses, ev.pulses);
      end
    end
  end

  initial begin
    int e;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // 1: mult
    issue(1'b1, 1'b0, 1'b0, 32'd0, e);
    repeat (N + 4) tick();
    chk("t1_queue_empty", q.size(), 0);

    // 2: div from MDR, divisor 7
    issue(1'b0, 1'b1, 1'b1, 32'd7, e);
    repeat (N + 4) tick();
    chk("t2_queue_empty", q.size(), 0);

    // 3: divide by zero (dividend from A)
    issue(1'b0, 1'b1, 1'b0, 32'd0, e);
    repeat (4) tick();
    chk("t3_queue_empty", q.size(), 0);

    // IDLE abort has priority: start ignored
    start_mult = 1'b1;
    abort      = 1'b1;
    tick();
    start_mult = 1'b0;
    abort      = 1'b0;
    repeat (3) tick();
    chk("idle_abort_queue", q.size(), 0);

    // 4: both starts -> mult only; start_div while busy ignored
    issue(1'b1, 1'b1, 1'b0, 32'd5, e);
    while (cyc < e + 8) tick();
    start_div   = 1'b1;
    div_src_mdr = 1'b1;
    divisor     = 32'd9;
    tick();
    start_div   = 1'b0;
    div_src_mdr = 1'b0;
    while (cyc < e + N + 6) tick();
    chk("t4_queue_empty", q.size(), 0);

    // 5: abort in cycle 20 of a mult, then a new div
    issue(1'b1, 1'b0, 1'b1, 32'd0, e);
    while (cyc < e + 19) tick();
    abort = 1'b1;
    tick();
    abort   = 1'b0;
    q.delete();
    busy_hi = e + 19;
    chk("t5_abort_busy", busy, 0);
    tick();
    issue(1'b0, 1'b1, 1'b0, 32'd11, e);
    repeat (N + 4) tick();
    chk("t5_queue_empty", q.size(), 0);

    // 6: async reset in cycle 15 of a div
    issue(1'b0, 1'b1, 1'b1, 32'd3, e);
    while (cyc < e + 14) tick();
    chk("t6_busy_before", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    busy_lo = 1; busy_hi = 0;
    exp_src = 1'b0; exp_op = 1'b0;
    check_all_zero("t6_async");
    tick(); tick();
    reset = 1'b1;
    tick();
    issue(1'b1, 1'b0, 1'b0, 32'd0, e);
    repeat (N + 4) tick();
    chk("t6_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_muldiv_sequencer
`default_nettype wire
